csi2rx_four_lane_lml: RTL and testbench

- Four-lane receive-side lane merging layer for the CSI-2 receiver, clocked on the D-PHY RX byte clock.
- Takes per-lane bytes from the PPI receive interface and extracts the 32-bit packet header.
- Packs payload plus CRC bytes into 64-bit words for the RX byte FIFO, and flags end of packet and framing errors.
- Sits between the D-PHY PPI RX and the RX packet/CRC layer.

---
 rtl/csi2rx_four_lane_lml.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_csi2rx_four_lane_lml.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi2rx_four_lane_lml.sv
// ---------------------------------------------------------------------------
// csi2rx_four_lane_lml
// Four-lane receive lane-merging layer for the CSI-2 receiver, running on the
// D-PHY RX byte clock. It sits between the PPI receive interface and the RX
// packet/CRC layer. It captures the 32-bit packet header from the first
// full-width beat. It then packs payload and CRC bytes, two 32-bit beats per
// word, into 64-bit words for the RX byte FIFO. It also flags end of packet
// and framing or overflow errors.
//
// Optional build macro: CSI2RX_ECC_CHECK_EN
//    When defined, the 6-bit CSI-2 header ECC is checked and ecc_err is
//    raised on a mismatch. When undefined, ecc_err is tied low.
//
// Ports:
//    rxbyteclkhs      RX byte clock
//    rxbyteclkhs_rst  synchronous active-high reset
//    four_lane_en     block enabled in 4-lane mode (sampled in IDLE only)
//    rxactivehs[3:0]  per-lane HS receive active (lane 0 governs framing)
//    rxsynchs[3:0]    per-lane sync-detected pulse (lane 0 used)
//    rxvalidhs[3:0]   per-lane byte valid
//    rxdatahs[31:0]   lane n byte on [8n+7:8n]
//    fifo_full        RX byte FIFO full
//    fifo_wr_en       registered FIFO write strobe
//    fifo_wr_data     packed bytes, first beat in [31:0]
//    fifo_wr_be       byte enables for fifo_wr_data
//    header_valid     one-cycle pulse, header_data valid
//    header_data      {ECC, WC[15:8], WC[7:0], DI}
//    short_packet     level, captured DI[5:0] < 6'h10
//    eop              one-cycle end-of-packet pulse
//    ecc_err          header ECC mismatch
//    rx_err           sticky framing/overflow error, cleared on entry to IDLE
// ---------------------------------------------------------------------------
module csi2rx_four_lane_lml #(
   parameter int WC_WIDTH = 17,
   parameter int FIFO_DW  = 64
) (
   input  logic                 rxbyteclkhs,
   input  logic                 rxbyteclkhs_rst,
   input  logic                 four_lane_en,
   input  logic [3:0]           rxactivehs,
   input  logic [3:0]           rxsynchs,
   input  logic [3:0]           rxvalidhs,
   input  logic [31:0]          rxdatahs,
   input  logic                 fifo_full,
   output logic                 fifo_wr_en,
   output logic [FIFO_DW-1:0]   fifo_wr_data,
   output logic [FIFO_DW/8-1:0] fifo_wr_be,
   output logic                 header_valid,
   output logic [31:0]          header_data,
   output logic                 short_packet,
   output logic                 eop,
   output logic                 ecc_err,
   output logic                 rx_err
);

   typedef enum logic [2:0] {IDLE, SYNC, HDR, PAYLOAD, FLUSH, WAIT_INACT} state_t;

   state_t                state_q, state_d;
   logic [WC_WIDTH-1:0]   remaining_q, remaining_d;
   logic                  toggle_q, toggle_d;
   logic [31:0]           packLow_q, packLow_d;
   logic [3:0]            packBe_q, packBe_d;
   logic [31:0]           headerData_q, headerData_d;
   logic                  headerValid_q, headerValid_d;
   logic                  shortPkt_q, shortPkt_d;
   logic                  eop_q, eop_d;
   logic                  rxErr_q, rxErr_d;
   logic                  wrEn_q, wrEn_d;
   logic [FIFO_DW-1:0]    wrData_q, wrData_d;
   logic [FIFO_DW/8-1:0]  wrBe_q, wrBe_d;

   logic                  writeReq;
   logic [FIFO_DW-1:0]    writeData;
   logic [FIFO_DW/8-1:0]  writeBe;
   logic                  clearOnIdle;
   logic [WC_WIDTH-1:0]   beatCnt;
   logic                  legalBeat;

   // Only lane 0 carries framing information; the other lanes' active and
   // sync flags are intentionally not looked at.
   logic unusedLaneFlags;
   assign unusedLaneFlags = ^{rxactivehs[3:1], rxsynchs[3:1]};

`ifdef CSI2RX_ECC_CHECK_EN
   logic eccErr_q, eccErr_d;

   // Each parity bit of the CSI-2 header ECC is the XOR of a fixed subset of
   // the 24 header data bits; the masks encode those subsets.
   function automatic logic [5:0] calcEcc(input logic [23:0] d);
      logic [5:0] p;
      p[0] = ^(d & 24'hF12CB7);
      p[1] = ^(d & 24'hF2555B);
      p[2] = ^(d & 24'h749A6D);
      p[3] = ^(d & 24'hB8E38E);
      p[4] = ^(d & 24'hDF03F0);
      p[5] = ^(d & 24'hEFFC00);
      return p;
   endfunction

   assign ecc_err = eccErr_q;
`else
   assign ecc_err = 1'b0;
`endif

   // Only contiguous low-lane patterns are legal, so the byte count of a beat
   // can be read straight off the pattern.
   always_comb begin
      beatCnt   = '0;
      legalBeat = 1'b1;
      case (rxvalidhs)
         4'b1111: beatCnt = WC_WIDTH'(4);
         4'b0111: beatCnt = WC_WIDTH'(3);
         4'b0011: beatCnt = WC_WIDTH'(2);
         4'b0001: beatCnt = WC_WIDTH'(1);
         default: legalBeat = 1'b0;
      endcase
   end

   // Next-state and datapath decisions. Every FIFO write request funnels
   // through writeReq, so the full check and the registered strobe are
   // handled in one place at the bottom.
   always_comb begin
      state_d       = state_q;
      remaining_d   = remaining_q;
      toggle_d      = toggle_q;
      packLow_d     = packLow_q;
      packBe_d      = packBe_q;
      headerData_d  = headerData_q;
      headerValid_d = 1'b0;
      shortPkt_d    = shortPkt_q;
      eop_d         = 1'b0;
      rxErr_d       = rxErr_q;
      wrEn_d        = 1'b0;
      wrData_d      = wrData_q;
      wrBe_d        = wrBe_q;
      writeReq      = 1'b0;
      writeData     = '0;
      writeBe       = '0;
      clearOnIdle   = 1'b0;
`ifdef CSI2RX_ECC_CHECK_EN
      eccErr_d      = eccErr_q;
`endif

      case (state_q)
         IDLE: begin
            if (four_lane_en && rxactivehs[0]) state_d = SYNC;
         end
         SYNC: begin
            if (!rxactivehs[0]) begin
               state_d     = IDLE;
               clearOnIdle = 1'b1;
            end else if (rxsynchs[0]) begin
               state_d = HDR;
            end
         end
         HDR: begin
            if (!rxactivehs[0]) begin
               rxErr_d = 1'b1;
               state_d = WAIT_INACT;
            end else if (rxvalidhs == 4'b1111) begin
               headerData_d  = rxdatahs;
               headerValid_d = 1'b1;
               shortPkt_d    = (rxdatahs[5:0] < 6'h10);
`ifdef CSI2RX_ECC_CHECK_EN
               eccErr_d = (calcEcc(rxdatahs[23:0]) != rxdatahs[29:24]) ||
                          (rxdatahs[31:30] != 2'b00);
`endif
               if (rxdatahs[5:0] < 6'h10) begin
                  eop_d   = 1'b1;
                  state_d = WAIT_INACT;
               end else begin
                  // The word count is followed by two CRC bytes.
                  remaining_d = WC_WIDTH'(rxdatahs[23:8]) + WC_WIDTH'(2);
                  state_d     = PAYLOAD;
               end
            end else if (rxvalidhs != 4'b0000) begin
               rxErr_d = 1'b1;
               state_d = WAIT_INACT;
            end
         end
         PAYLOAD: begin
            if (!rxactivehs[0]) begin
               state_d = FLUSH;
            end else if (rxvalidhs != 4'b0000) begin
               if (!legalBeat) begin
                  rxErr_d = 1'b1;
                  state_d = WAIT_INACT;
               end else begin
                  if (toggle_q) begin
                     writeReq  = 1'b1;
                     writeData = {rxdatahs, packLow_q};
                     writeBe   = {rxvalidhs, packBe_q};
                  end else begin
                     packLow_d = rxdatahs;
                     packBe_d  = rxvalidhs;
                  end
                  toggle_d = ~toggle_q;
                  if (remaining_q <= WC_WIDTH'(4)) begin
                     // Last beat: push out whatever is packed, even a lone
                     // low half, and finish the packet.
                     if (beatCnt != remaining_q) rxErr_d = 1'b1;
                     if (!toggle_q) begin
                        writeReq  = 1'b1;
                        writeData = {32'h0, rxdatahs};
                        writeBe   = {4'h0, rxvalidhs};
                     end
                     remaining_d = (beatCnt > remaining_q) ? '0 : remaining_q - beatCnt;
                     toggle_d    = 1'b0;
                     eop_d       = 1'b1;
                     state_d     = WAIT_INACT;
                  end else begin
                     remaining_d = remaining_q - beatCnt;
                  end
               end
            end
         end
         FLUSH: begin
            // Lane 0 dropped mid-packet: salvage any held low half.
            writeReq  = toggle_q;
            writeData = {32'h0, packLow_q};
            writeBe   = {4'h0, packBe_q};
            toggle_d  = 1'b0;
            eop_d     = 1'b1;
            rxErr_d   = 1'b1;
            state_d   = WAIT_INACT;
         end
         WAIT_INACT: begin
            if (!rxactivehs[0]) begin
               state_d     = IDLE;
               clearOnIdle = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A write that meets a full FIFO is dropped and reported, and
      // reception carries on.
      if (writeReq) begin
         if (fifo_full) begin
            rxErr_d = 1'b1;
         end else begin
            wrEn_d   = 1'b1;
            wrData_d = writeData;
            wrBe_d   = writeBe;
         end
      end

      if (clearOnIdle) begin
         rxErr_d     = 1'b0;
         shortPkt_d  = 1'b0;
         toggle_d    = 1'b0;
         remaining_d = '0;
         packLow_d   = '0;
         packBe_d    = '0;
`ifdef CSI2RX_ECC_CHECK_EN
         eccErr_d    = 1'b0;
`endif
      end
   end

   // State and output registers; reset clears everything, including a
   // packet in flight.
   always_ff @(posedge rxbyteclkhs) begin
      if (rxbyteclkhs_rst) begin
         state_q       <= IDLE;
         remaining_q   <= '0;
         toggle_q      <= 1'b0;
         packLow_q     <= '0;
         packBe_q      <= '0;
         headerData_q  <= '0;
         headerValid_q <= 1'b0;
         shortPkt_q    <= 1'b0;
         eop_q         <= 1'b0;
         rxErr_q       <= 1'b0;
         wrEn_q        <= 1'b0;
         wrData_q      <= '0;
         wrBe_q        <= '0;
`ifdef CSI2RX_ECC_CHECK_EN
         eccErr_q      <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         remaining_q   <= remaining_d;
         toggle_q      <= toggle_d;
         packLow_q     <= packLow_d;
         packBe_q      <= packBe_d;
         headerData_q  <= headerData_d;
         headerValid_q <= headerValid_d;
         shortPkt_q    <= shortPkt_d;
         eop_q         <= eop_d;
         rxErr_q       <= rxErr_d;
         wrEn_q        <= wrEn_d;
         wrData_q      <= wrData_d;
         wrBe_q        <= wrBe_d;
`ifdef CSI2RX_ECC_CHECK_EN
         eccErr_q      <= eccErr_d;
`endif
      end
   end

   assign fifo_wr_en   = wrEn_q;
   assign fifo_wr_data = wrData_q;
   assign fifo_wr_be   = wrBe_q;
   assign header_valid = headerValid_q;
   assign header_data  = headerData_q;
   assign short_packet = shortPkt_q;
   assign eop          = eop_q;
   assign rx_err       = rxErr_q;

endmodule

// File: tb/tb_csi2rx_four_lane_lml.sv
// ---------------------------------------------------------------------------
// tb_csi2rx_four_lane_lml
// Directed bench for the four-lane CSI-2 lane merging layer. Inputs change on
// the falling clock edge, and outputs are read on the next falling edge. That
// way, a registered response to a beat is visible as soon as the beat's
// stimulus call returns.
// ---------------------------------------------------------------------------
module tb_csi2rx_four_lane_lml;

   logic        clk;
   logic        rst;
   logic        laneEn;
   logic [3:0]  active;
   logic [3:0]  syncs;
   logic [3:0]  valid;
   logic [31:0] data;
   logic        full;
   logic        wrEn;
   logic [63:0] wrData;
   logic [7:0]  wrBe;
   logic        hdrValid;
   logic [31:0] hdrData;
   logic        shortPkt;
   logic        eopPulse;
   logic        eccErr;
   logic        rxErr;

   int vectors;
   int miscompares;

   csi2rx_four_lane_lml dut (
      .rxbyteclkhs     (clk),
      .rxbyteclkhs_rst (rst),
      .four_lane_en    (laneEn),
      .rxactivehs      (active),
      .rxsynchs        (syncs),
      .rxvalidhs       (valid),
      .rxdatahs        (data),
      .fifo_full       (full),
      .fifo_wr_en      (wrEn),
      .fifo_wr_data    (wrData),
      .fifo_wr_be      (wrBe),
      .header_valid    (hdrValid),
      .header_data     (hdrData),
      .short_packet    (shortPkt),
      .eop             (eopPulse),
      .ecc_err         (eccErr),
      .rx_err          (rxErr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of lane inputs and return at the next falling edge, after
   // the DUT has registered its response.
   task automatic applyStimulus(input logic act, input logic syn, input logic [3:0] vld,
                                input logic [31:0] dat, input logic fl);
      active = {3'b000, act};
      syncs  = {3'b000, syn};
      valid  = vld;
      data   = dat;
      full   = fl;
      @(negedge clk);
   endtask

   // Bring the link up and deliver a header beat; returns in the cycle where
   // header_valid is expected.
   task automatic sendHeader(input logic [31:0] hdr);
      applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b1, 4'h0, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'hF, hdr, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
      vectors++;
      if ({wrEn, hdrValid, shortPkt, eopPulse, eccErr, rxErr} !== 6'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_flags got %b want 000000",
                  {wrEn, hdrValid, shortPkt, eopPulse, eccErr, rxErr});
      end
      vectors++;
      if (hdrData !== 32'h0 || wrData !== 64'h0 || wrBe !== 8'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_data got hdr=%h data=%h be=%h want zeros", hdrData, wrData, wrBe);
      end
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
   endtask

   task automatic test_short_packet();
      sendHeader(32'h2D00_0100);
      vectors++;
      if (hdrValid !== 1'b1 || hdrData !== 32'h2D00_0100) begin
         miscompares++;
         $display("[TB] FAIL short_hdr got valid=%b data=%h want 1 2d000100", hdrValid, hdrData);
      end
      vectors++;
      if (shortPkt !== 1'b1 || eopPulse !== 1'b1 || wrEn !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL short_flags got short=%b eop=%b wr=%b want 1 1 0", shortPkt, eopPulse, wrEn);
      end
      vectors++;
`ifdef CSI2RX_ECC_CHECK_EN
      if (eccErr !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL short_ecc got %b want 1", eccErr);
      end
`else
      if (eccErr !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL short_ecc got %b want 0", eccErr);
      end
`endif
      applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
      vectors++;
      if (hdrValid !== 1'b0 || eopPulse !== 1'b0 || shortPkt !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL short_after got valid=%b eop=%b short=%b want 0 0 1", hdrValid, eopPulse, shortPkt);
      end
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
      vectors++;
      if (shortPkt !== 1'b0 || hdrData !== 32'h2D00_0100) begin
         miscompares++;
         $display("[TB] FAIL short_idle got short=%b hdr=%h want 0 2d000100", shortPkt, hdrData);
      end
   endtask

   // WC=8 -> 10 bytes: two full beats then a two-byte tail.
   task automatic test_long_wc8();
      sendHeader(32'h0000_082A);
      vectors++;
      if (hdrValid !== 1'b1 || shortPkt !== 1'b0 || wrEn !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL wc8_hdr got valid=%b short=%b wr=%b want 1 0 0", hdrValid, shortPkt, wrEn);
      end
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h0302_0100, 1'b0);
      vectors++;
      if (wrEn !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL wc8_b0 got wr=%b want 0", wrEn);
      end
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h0706_0504, 1'b0);
      vectors++;
      if (wrEn !== 1'b1 || wrData !== 64'h0706_0504_0302_0100 || wrBe !== 8'hFF || eopPulse !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL wc8_w0 got wr=%b data=%h be=%h eop=%b want 1 0706050403020100 ff 0",
                  wrEn, wrData, wrBe, eopPulse);
      end
      applyStimulus(1'b1, 1'b0, 4'h3, 32'h0000_0908, 1'b0);
      vectors++;
      if (wrEn !== 1'b1 || wrData[31:0] !== 32'h0000_0908 || wrBe !== 8'h03 || eopPulse !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL wc8_w1 got wr=%b low=%h be=%h eop=%b want 1 00000908 03 1",
                  wrEn, wrData[31:0], wrBe, eopPulse);
      end
      vectors++;
      if (rxErr !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL wc8_err got %b want 0", rxErr);
      end
      applyStimulus(1'b1, 1'b0, 4'hF, 32'hFFFF_FFFF, 1'b0);
      vectors++;
      if (wrEn !== 1'b0 || eopPulse !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL wc8_quiet got wr=%b eop=%b want 0 0", wrEn, eopPulse);
      end
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
   endtask

   // WC=10 -> 12 bytes: last beat lands in the low half.
   task automatic test_long_wc10();
      sendHeader(32'h0000_0A2A);
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h1111_1111, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h2222_2222, 1'b0);
      vectors++;
      if (wrEn !== 1'b1 || wrBe !== 8'hFF || wrData !== 64'h2222_2222_1111_1111) begin
         miscompares++;
         $display("[TB] FAIL wc10_w0 got wr=%b be=%h data=%h want 1 ff 2222222211111111", wrEn, wrBe, wrData);
      end
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h3333_3333, 1'b0);
      vectors++;
      if (wrEn !== 1'b1 || wrBe !== 8'h0F || wrData[31:0] !== 32'h3333_3333 || eopPulse !== 1'b1 || rxErr !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL wc10_w1 got wr=%b be=%h low=%h eop=%b err=%b want 1 0f 33333333 1 0",
                  wrEn, wrBe, wrData[31:0], eopPulse, rxErr);
      end
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
   endtask

   // Last beat completing the high half: a single write with the partial mask.
   task automatic test_high_half_tail();
      sendHeader(32'h0000_052A);
      applyStimulus(1'b1, 1'b0, 4'hF, 32'hA3A2_A1A0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'h7, 32'h00B2_B1B0, 1'b0);
      vectors++;
      if (wrEn !== 1'b1 || wrBe !== 8'h7F || wrData !== 64'h00B2_B1B0_A3A2_A1A0 || eopPulse !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL tail_hi got wr=%b be=%h data=%h eop=%b want 1 7f 00b2b1b0a3a2a1a0 1",
                  wrEn, wrBe, wrData, eopPulse);
      end
      applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
      vectors++;
      if (wrEn !== 1'b0 || rxErr !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL tail_hi_after got wr=%b err=%b want 0 0", wrEn, rxErr);
      end
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
   endtask

   // FIFO full when word0 is due: word0 dropped, word1 still written.
   task automatic test_fifo_full();
      sendHeader(32'h0000_082A);
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h0302_0100, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h0706_0504, 1'b1);
      vectors++;
      if (wrEn !== 1'b0 || rxErr !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL full_drop got wr=%b err=%b want 0 1", wrEn, rxErr);
      end
      applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 4'h3, 32'h0000_0908, 1'b0);
      vectors++;
      if (wrEn !== 1'b1 || wrBe !== 8'h03 || eopPulse !== 1'b1 || rxErr !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL full_w1 got wr=%b be=%h eop=%b err=%b want 1 03 1 1", wrEn, wrBe, eopPulse, rxErr);
      end
      applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
      vectors++;
      if (rxErr !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL full_sticky got %b want 1", rxErr);
      end
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
      vectors++;
      if (rxErr !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL full_idle_clear got %b want 0", rxErr);
      end
   endtask

   // Lane 0 drops after one payload beat: the held low half is flushed.
   task automatic test_flush();
      sendHeader(32'h0000_102A);
      applyStimulus(1'b1, 1'b0, 4'hF, 32'hDDCC_BBAA, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
      vectors++;
      if (wrEn !== 1'b0 || eopPulse !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL flush_enter got wr=%b eop=%b want 0 0", wrEn, eopPulse);
      end
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
      vectors++;
      if (wrEn !== 1'b1 || wrBe !== 8'h0F || wrData[31:0] !== 32'hDDCC_BBAA || eopPulse !== 1'b1 || rxErr !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL flush_write got wr=%b be=%h low=%h eop=%b err=%b want 1 0f ddccbbaa 1 1",
                  wrEn, wrBe, wrData[31:0], eopPulse, rxErr);
      end
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
      vectors++;
      if (rxErr !== 1'b0 || eopPulse !== 1'b0 || hdrData !== 32'h0000_102A) begin
         miscompares++;
         $display("[TB] FAIL flush_idle got err=%b eop=%b hdr=%h want 0 0 0000102a", rxErr, eopPulse, hdrData);
      end
   endtask

   task automatic test_bad_pattern();
      sendHeader(32'h0000_082A);
      applyStimulus(1'b1, 1'b0, 4'h5, 32'h1234_5678, 1'b0);
      vectors++;
      if (rxErr !== 1'b1 || wrEn !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL badpat got err=%b wr=%b want 1 0", rxErr, wrEn);
      end
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h0, 1'b0);
      vectors++;
      if (wrEn !== 1'b0 || rxErr !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL badpat_wait got wr=%b err=%b want 0 1", wrEn, rxErr);
      end
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
   endtask

   task automatic test_reset_mid_payload();
      sendHeader(32'h0000_102A);
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h0101_0101, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h0202_0202, 1'b0);
      vectors++;
      if (wrEn !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL midrst_pre got wr=%b want 1", wrEn);
      end
      rst = 1'b1;
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h0303_0303, 1'b0);
      rst = 1'b0;
      vectors++;
      if ({wrEn, hdrValid, shortPkt, eopPulse, eccErr, rxErr} !== 6'b0 || hdrData !== 32'h0 || wrBe !== 8'h0) begin
         miscompares++;
         $display("[TB] FAIL midrst_outs got flags=%b hdr=%h be=%h want 000000 0 0",
                  {wrEn, hdrValid, shortPkt, eopPulse, eccErr, rxErr}, hdrData, wrBe);
      end
      // From IDLE a full-width beat only starts sync hunting; no header.
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h0000_082A, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h0000_082A, 1'b0);
      vectors++;
      if (hdrValid !== 1'b0 || wrEn !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midrst_idle got hv=%b wr=%b want 0 0", hdrValid, wrEn);
      end
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
   endtask

   task automatic test_lane_disable();
      laneEn = 1'b0;
      sendHeader(32'h0000_0100);
      vectors++;
      if (hdrValid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL disabled_hdr got %b want 0", hdrValid);
      end
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
      laneEn = 1'b1;
   endtask

`ifdef CSI2RX_ECC_CHECK_EN
   // Header 0x000100 has ECC 0x1A; flipping ECC bit 0 must be flagged.
   task automatic test_ecc();
      sendHeader(32'h1A00_0100);
      vectors++;
      if (eccErr !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ecc_good got %b want 0", eccErr);
      end
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
      sendHeader(32'h1B00_0100);
      vectors++;
      if (eccErr !== 1'b1 || hdrValid !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL ecc_bad got ecc=%b hv=%b want 1 1", eccErr, hdrValid);
      end
      applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
      vectors++;
      if (eccErr !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL ecc_hold got %b want 1", eccErr);
      end
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
      vectors++;
      if (eccErr !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ecc_idle got %b want 0", eccErr);
      end
   endtask
`endif

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      laneEn      = 1'b1;
      active      = 4'h0;
      syncs       = 4'h0;
      valid       = 4'h0;
      data        = 32'h0;
      full        = 1'b0;
      @(negedge clk);
      test_reset();
      test_short_packet();
      test_long_wc8();
      test_long_wc10();
      test_high_half_tail();
      test_fifo_full();
      test_flush();
      test_bad_pattern();
      test_reset_mid_payload();
      test_lane_disable();
`ifdef CSI2RX_ECC_CHECK_EN
      test_ecc();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
